// File: rtl/fpsu_flag_retire.sv
// FP flag retire stage: masks per-lane raised flags with trap enables, pipelines retire codes, keeps sticky status.
// Optional trapped-event counter enabled by defining FPSU_TRAP_COUNT_EN.
module fpsu_flag_retire #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAGW  = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [10:0]     u1_raise,
    input  logic            u1_vld,
    input  logic [TAGW-1:0] u1_tag,
    input  logic [10:0]     u2_raise,
    input  logic            u2_vld,
    input  logic [TAGW-1:0] u2_tag,
    input  logic [10:0]     trap_en,
    input  logic            flush,
    input  logic            sticky_clr,
    output logic [10:0]     sticky,
    output logic [TAGW+3:0] u1_ret,
    output logic            u1_ret_en,
    output logic [TAGW+3:0] u2_ret,
    output logic            u2_ret_en,
    output logic [15:0]     trap_cnt
);

    function automatic logic [3:0] trap_code(input logic [10:0] t);
        logic [3:0] c;
        casez (t)
            11'b1??????????: c = 4'd11;
            11'b01?????????: c = 4'd10;
            11'b001????????: c = 4'd9;
            11'b0001???????: c = 4'd8;
            11'b00001??????: c = 4'd7;
            11'b000001?????: c = 4'd6;
            11'b0000001????: c = 4'd5;
            11'b00000001???: c = 4'd4;
            11'b000000001??: c = 4'd3;
            11'b0000000001?: c = 4'd2;
            11'b00000000001: c = 4'd1;
            default:         c = 4'd0;
        endcase
        return c;
    endfunction

    logic [3:0]  code1, code2;
    logic [10:0] sticky_d, sticky_q;

    always_comb begin
        code1    = trap_code(u1_raise & trap_en);
        code2    = trap_code(u2_raise & trap_en);
        sticky_d = sticky_clr ? '0 : sticky_q;
        if (u1_vld) sticky_d = sticky_d | (u1_raise & ~trap_en);
        if (u2_vld) sticky_d = sticky_d | (u2_raise & ~trap_en);
    end

    always_ff @(posedge clk) begin
        if (rst) sticky_q <= '0;
        else     sticky_q <= sticky_d;
    end

    // Data fields only load alongside a surviving valid, so the last stage
    // (and hence u*_ret) holds its value across idle and flushed cycles.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic            v1_in, v2_in;
        logic [3:0]      c1_in, c2_in;
        logic [TAGW-1:0] g1_in, g2_in;
        logic            v1_q, v2_q;
        logic [3:0]      c1_q, c2_q;
        logic [TAGW-1:0] g1_q, g2_q;

        if (k == 0) begin : g_src
            assign v1_in = u1_vld;
            assign c1_in = code1;
            assign g1_in = u1_tag;
            assign v2_in = u2_vld;
            assign c2_in = code2;
            assign g2_in = u2_tag;
        end else begin : g_src
            assign v1_in = g_stage[k-1].v1_q;
            assign c1_in = g_stage[k-1].c1_q;
            assign g1_in = g_stage[k-1].g1_q;
            assign v2_in = g_stage[k-1].v2_q;
            assign c2_in = g_stage[k-1].c2_q;
            assign g2_in = g_stage[k-1].g2_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v1_q <= 1'b0;
                c1_q <= '0;
                g1_q <= '0;
                v2_q <= 1'b0;
                c2_q <= '0;
                g2_q <= '0;
            end else begin
                v1_q <= v1_in & ~flush;
                v2_q <= v2_in & ~flush;
                if (v1_in && !flush) begin
                    c1_q <= c1_in;
                    g1_q <= g1_in;
                end
                if (v2_in && !flush) begin
                    c2_q <= c2_in;
                    g2_q <= g2_in;
                end
            end
        end
    end

    assign sticky    = sticky_q;
    assign u1_ret_en = g_stage[DEPTH-1].v1_q;
    assign u1_ret    = {g_stage[DEPTH-1].c1_q, g_stage[DEPTH-1].g1_q};
    assign u2_ret_en = g_stage[DEPTH-1].v2_q;
    assign u2_ret    = {g_stage[DEPTH-1].c2_q, g_stage[DEPTH-1].g2_q};

`ifdef FPSU_TRAP_COUNT_EN
    logic [1:0]  inc;
    logic [16:0] sum;
    logic [15:0] cnt_d, cnt_q;

    always_comb begin
        inc   = {1'b0, u1_ret_en && (g_stage[DEPTH-1].c1_q != 4'd0)}
              + {1'b0, u2_ret_en && (g_stage[DEPTH-1].c2_q != 4'd0)};
        sum   = {1'b0, cnt_q} + {15'd0, inc};
        cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
        if (sticky_clr) cnt_d = {14'd0, inc};
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign trap_cnt = cnt_q;
`else
    assign trap_cnt = '0;
`endif

endmodule

// File: tb/tb_fpsu_flag_retire.sv
// Scoreboard bench for fpsu_flag_retire: directed steps plus a short random burst.
module tb_fpsu_flag_retire;

    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [31:0] due;
        logic [13:0] ret;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] u1_raise = '0, u2_raise = '0, trap_en = '0;
    logic        u1_vld = 1'b0, u2_vld = 1'b0, flush = 1'b0, sticky_clr = 1'b0;
    logic [9:0]  u1_tag = '0, u2_tag = '0;
    logic [10:0] sticky;
    logic [13:0] u1_ret, u2_ret;
    logic        u1_ret_en, u2_ret_en;
    logic [15:0] trap_cnt;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          armed = 1'b0;
    ent_t        q1[$];
    ent_t        q2[$];
    logic [13:0] last1 = '0, last2 = '0;
    logic [10:0] sticky_m = '0;
    logic [15:0] cnt_m = '0;

    always #5 clk = ~clk;

    fpsu_flag_retire #(.DEPTH(DEPTH), .TAGW(10)) dut (
        .clk(clk), .rst(rst),
        .u1_raise(u1_raise), .u1_vld(u1_vld), .u1_tag(u1_tag),
        .u2_raise(u2_raise), .u2_vld(u2_vld), .u2_tag(u2_tag),
        .trap_en(trap_en), .flush(flush), .sticky_clr(sticky_clr),
        .sticky(sticky),
        .u1_ret(u1_ret), .u1_ret_en(u1_ret_en),
        .u2_ret(u2_ret), .u2_ret_en(u2_ret_en),
        .trap_cnt(trap_cnt)
    );

    function automatic logic [3:0] ref_code(input logic [10:0] t);
        logic [10:0] x;
        logic [3:0]  c;
        x = t;
        c = 4'd0;
        for (int i = 1; i <= 11; i++) begin
            if (x[0]) c = 4'(i);
            x = x >> 1;
        end
        return c;
    endfunction

    task automatic lane_chk(input string nm, input logic en, input logic [13:0] ret,
                            input bit have, input ent_t fr, inout logic [13:0] last,
                            output bit pop, output bit trapped);
        bit exp_en;
        exp_en  = have && (fr.due == cyc);
        pop     = have && (fr.due <= cyc);
        trapped = exp_en && (fr.ret[13:10] != 4'd0);
        checks++;
        assert (en === exp_en) else begin
            errors++;
            $error("FAIL %s_ret_en observed %b expected %b (cycle %0d)", nm, en, exp_en, cyc);
        end
        checks++;
        if (exp_en) begin
            assert (ret === fr.ret) else begin
                errors++;
                $error("FAIL %s_ret observed %h expected %h", nm, ret, fr.ret);
            end
            last = fr.ret;
        end else begin
            assert (ret === last) else begin
                errors++;
                $error("FAIL %s_ret_hold observed %h expected %h", nm, ret, last);
            end
        end
    endtask

    task automatic step(input logic v1, input logic [10:0] r1, input logic [9:0] g1,
                        input logic v2, input logic [10:0] r2, input logic [9:0] g2,
                        input logic [10:0] te, input logic fl, input logic clr);
        ent_t e;
        u1_vld = v1; u1_raise = r1; u1_tag = g1;
        u2_vld = v2; u2_raise = r2; u2_tag = g2;
        trap_en = te; flush = fl; sticky_clr = clr;
        if (fl) begin
            while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
            while (q2.size() > 0 && q2[$].due > cyc) void'(q2.pop_back());
        end else begin
            e.due = cyc + DEPTH;
            if (v1) begin e.ret = {ref_code(r1 & te), g1}; q1.push_back(e); end
            if (v2) begin e.ret = {ref_code(r2 & te), g2}; q2.push_back(e); end
        end
        sticky_m = (clr ? 11'd0 : sticky_m) | (v1 ? (r1 & ~te) : 11'd0) | (v2 ? (r2 & ~te) : 11'd0);
        @(posedge clk); #1;
        checks++;
        assert (sticky === sticky_m) else begin
            errors++;
            $error("FAIL sticky observed %h expected %h", sticky, sticky_m);
        end
    endtask

    task automatic idle(input int n, input logic [10:0] te);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, te, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        u1_vld = 0; u2_vld = 0; flush = 0; sticky_clr = 0;
        while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
        while (q2.size() > 0 && q2[$].due > cyc) void'(q2.pop_back());
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            sticky_m = '0; last1 = '0; last2 = '0;
        end
        rst = 1'b0;
    endtask

    task automatic chk_outs_zero(input string nm);
        checks++;
        assert ({u1_ret_en, u2_ret_en, u1_ret, u2_ret, sticky, trap_cnt} === '0) else begin
            errors++;
            $error("FAIL %s observed en=%b%b r1=%h r2=%h st=%h cnt=%h expected all zero",
                   nm, u1_ret_en, u2_ret_en, u1_ret, u2_ret, sticky, trap_cnt);
        end
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                bit   p1, p2, t1, t2;
                ent_t f1, f2;
                logic [16:0] sum;
                @(negedge clk);
                if (armed) begin
                    f1 = '0; if (q1.size() > 0) f1 = q1[0];
                    f2 = '0; if (q2.size() > 0) f2 = q2[0];
                    lane_chk("u1", u1_ret_en, u1_ret, q1.size() > 0, f1, last1, p1, t1);
                    lane_chk("u2", u2_ret_en, u2_ret, q2.size() > 0, f2, last2, p2, t2);
                    if (p1) void'(q1.pop_front());
                    if (p2) void'(q2.pop_front());
                    checks++;
                    assert (trap_cnt === cnt_m) else begin
                        errors++;
                        $error("FAIL trap_cnt observed %h expected %h", trap_cnt, cnt_m);
                    end
`ifdef FPSU_TRAP_COUNT_EN
                    sum = {1'b0, cnt_m} + {16'd0, t1} + {16'd0, t2};
                    if (rst)             cnt_m = '0;
                    else if (sticky_clr) cnt_m = {14'd0, 2'({1'b0, t1} + {1'b0, t2})};
                    else                 cnt_m = sum[16] ? 16'hFFFF : sum[15:0];
`endif
                end
            end
        join_none

        do_reset(2);
        chk_outs_zero("reset_state");
        armed = 1'b1;

        // Basic trap: raise 0x011 with trap_en 0x010 -> code 5, sticky 0x001.
        step(1, 11'h011, 10'h155, 0, '0, '0, 11'h010, 0, 0);
        step(0, '0, '0, 0, '0, '0, 11'h010, 0, 0);
        checks++;
        assert ({u1_ret_en, u1_ret} === {1'b1, 14'h1555}) else begin
            errors++;
            $error("FAIL basic_ret observed %b/%h expected 1/1555", u1_ret_en, u1_ret);
        end
        idle(2, 11'h010);

        // Dual lane, everything trapped.
        step(0, '0, '0, 0, '0, '0, 11'h7FF, 0, 1);
        step(1, 11'h400, 10'h2AA, 1, 11'h001, 10'h0CC, 11'h7FF, 0, 0);
        idle(3, 11'h7FF);

        // Flush kills in-flight u2 entry and the u1 entry captured on the flush edge.
        step(0, '0, '0, 1, 11'h0F3, 10'h3C3, 11'h00F, 0, 0);
        step(1, 11'h100, 10'h011, 0, '0, '0, 11'h00F, 1, 0);
        idle(3, 11'h00F);

        // Clear collisions: same-edge raise survives sticky_clr.
        step(1, 11'h0F0, 10'h001, 0, '0, '0, 11'h000, 0, 1);
        step(1, 11'h002, 10'h002, 0, '0, '0, 11'h000, 0, 1);
        checks++;
        assert (sticky === 11'h002) else begin
            errors++;
            $error("FAIL clr_collision observed %h expected 002", sticky);
        end
        idle(3, 11'h000);

        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 11'($urandom), 10'($urandom),
                 1'($urandom_range(0, 1)), 11'($urandom), 10'($urandom),
                 11'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end
        idle(3, 11'h7FF);

        // Reset while entries are in flight.
        step(1, 11'h7FF, 10'h3FF, 1, 11'h7FF, 10'h3FF, 11'h0F0, 0, 0);
        do_reset(1);
        idle(4, 11'h7FF);
        chk_outs_zero("reset_midflight");

`ifdef FPSU_TRAP_COUNT_EN
        step(0, '0, '0, 0, '0, '0, 11'h7FF, 0, 1);
        for (int i = 0; i < 32767; i++)
            step(1, 11'h001, 10'(i), 1, 11'h400, 10'(i), 11'h7FF, 0, 0);
        idle(3, 11'h7FF);
        checks++;
        assert (trap_cnt === 16'hFFFE) else begin
            errors++;
            $error("FAIL cnt_preload observed %h expected FFFE", trap_cnt);
        end
        step(1, 11'h001, 10'h001, 1, 11'h002, 10'h002, 11'h7FF, 0, 0);
        idle(3, 11'h7FF);
        checks++;
        assert (trap_cnt === 16'hFFFF) else begin
            errors++;
            $error("FAIL cnt_sat observed %h expected FFFF", trap_cnt);
        end
        step(1, 11'h001, 10'h001, 0, '0, '0, 11'h7FF, 0, 0);
        idle(3, 11'h7FF);
        checks++;
        assert (trap_cnt === 16'hFFFF) else begin
            errors++;
            $error("FAIL cnt_hold observed %h expected FFFF", trap_cnt);
        end
        step(0, '0, '0, 0, '0, '0, 11'h7FF, 0, 1);
        checks++;
        assert (trap_cnt === 16'h0000) else begin
            errors++;
            $error("FAIL cnt_clr observed %h expected 0000", trap_cnt);
        end
        idle(2, 11'h7FF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpsu_flag_retire.md
Name: fpsu_flag_retire

Overview:
- Stage directly downstream of the FP add/convert unit's two result lanes (add lane u1, cadd/mul lane u2).
- Takes the per-lane 11-bit raised-exception vectors and the op tag, masks them with the trap enables, and delays them to retire alignment.
- Produces the 14-bit retire code and strobe for each lane.
- Accumulates untrapped flags into a sticky status register that the CSR path reads and clears.

Parameters:
- DEPTH, 2, pipeline stages from input to u*_ret (legal 1..4).
- TAGW, 10, width of the per-op retire tag.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- u1_raise  in  11  raised FP flags, lane 1.
- u1_vld  in  1  lane 1 op completes this cycle.
- u1_tag  in  TAGW  retire tag, lane 1.
- u2_raise  in  11  raised FP flags, lane 2.
- u2_vld  in  1  lane 2 op completes this cycle.
- u2_tag  in  TAGW  retire tag, lane 2.
- trap_en  in  11  per-flag trap enables (fpcsr[21:11] image).
- flush  in  1  kill all in-flight entries.
- sticky_clr  in  1  clear sticky flags (CSR write pulse).
- sticky  out  11  accumulated untrapped flags.
- u1_ret  out  14  {code[3:0], tag[9:0]}, lane 1.
- u1_ret_en  out  1  retire strobe, lane 1.
- u2_ret  out  14  retire code, lane 2.
- u2_ret_en  out  1  retire strobe, lane 2.
- trap_cnt  out  16  trapped-event counter (see optional feature).

Behaviour:
- Reset (rst=1 at posedge): all pipeline valids=0; u1_ret/u2_ret=0; u*_ret_en=0; sticky=0; trap_cnt=0. Reset overrides flush, sticky_clr and inputs on the same edge.
- Stage 0 (input register) computes per lane:
  - t = raise & trap_en.
  - code = 0 if t==0, else (index of highest set bit of t)+1, giving range 1..11.
  - u = raise & ~trap_en.
- Stages 1..DEPTH-1 shift {vld, code, tag}.
- u*_ret_en is registered and equals the valid bit of the last stage; latency is exactly DEPTH cycles from u*_vld to u*_ret_en.
- When u*_ret_en=0, u*_ret holds its last value (not cleared).
- Lanes are independent. Both may retire in the same cycle with no ordering constraint.
- flush=1: clears every stage's valid bit on that edge, including the entry being captured that cycle, so u*_ret_en=0 on the next edge. Data fields are not cleared.
- Sticky update happens at stage 0 capture, not at retire:
  - sticky_next = (sticky_clr ? 0 : sticky) | (u1_vld ? u1_u : 0) | (u2_vld ? u2_u : 0).
  - A raise arriving on the same edge as sticky_clr survives the clear.
  - flush does not retract sticky bits already set, nor ones set on the same edge.
- trap_en is sampled at stage 0 only. Later changes do not affect entries already in flight.
- raise with u*_vld=0 is ignored entirely: no sticky update, no count.

Optional Feature:
- Macro: FPSU_TRAP_COUNT_EN.
- Defined:
  - trap_cnt is a 16-bit saturating counter, incremented at retire by (u1_ret_en && code!=0) + (u2_ret_en && code!=0), i.e. +0, +1 or +2.
  - It saturates at 16'hFFFF; from 16'hFFFE, +2 gives 16'hFFFF.
  - It is cleared by rst and by sticky_clr. On simultaneous clear and increment, the result is the increment value.
  - Flushed entries never count.
- Undefined: trap_cnt is tied to 16'h0 and no counter flops exist.

Test Plan:
- Basic trap, DEPTH=2, trap_en=11'h010:
  - stimulus: u1_vld=1, u1_raise=11'h011, u1_tag=10'h155 at cycle 0.
  - response: u1_ret_en=1 at cycle 2 only; u1_ret={4'd5,10'h155}; sticky=11'h001 from cycle 1.
- Dual lane, trap_en=11'h7FF:
  - stimulus: u1_raise=11'h400, u2_raise=11'h001, both vld in the same cycle.
  - response: both ret_en at +2; codes 4'd11 and 4'd1; sticky stays 0.
- Flush:
  - stimulus: issue on u2 at cycle 0; flush=1 at cycle 1.
  - response: u2_ret_en stays 0 at cycle 2; u2_ret unchanged; sticky keeps any untrapped bits set at cycle 0.
- Clear collision, trap_en=0, sticky=11'h0F0:
  - stimulus: sticky_clr=1 together with u1_vld=1, u1_raise=11'h002.
  - response: sticky=11'h002 next cycle.
- Reset mid-flight:
  - stimulus: rst=1 one cycle after a valid issue.
  - response: no ret_en ever; sticky=0; trap_cnt=0; outputs 0.
- With FPSU_TRAP_COUNT_EN defined:
  - stimulus: preload trap_cnt to 16'hFFFE via 65534 trapped retires (or force), then a dual trapped retire.
  - response: trap_cnt=16'hFFFF; a further retire leaves it at 16'hFFFF; sticky_clr returns it to 0.
